// File: rtl/lane_seq_pkg.sv
// Shared types for the lane enable sequencer and its decode helpers.
package lane_seq_pkg;
   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      SINGLE = 2'd0,
      SWEEP  = 2'd1,
      BCAST  = 2'd2,
      RSVD   = 2'd3
   } mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/onehot_dec_en.sv
// Combinational code-to-one-hot decoder with enable; codes >= OUT_W decode to zero.
module onehot_dec_en #(
   parameter int CODE_W = 3,
   parameter int OUT_W  = 8
) (
   input  logic [CODE_W-1:0] code,
   input  logic              en,
   output logic [OUT_W-1:0]  out
);
   always_comb begin
      out = '0;
      for (int i = 0; i < OUT_W; i++) out[i] = en && (code == CODE_W'(i));
   end
endmodule

// File: rtl/lane_enable_sequencer.sv
// Accepts {code, count, mode} and emits one registered enable word per cycle,
// walking lanes with wrap at OUT_W; en stalls the sweep and gates the output.
module lane_enable_sequencer
   import lane_seq_pkg::*;
#(
   parameter int CODE_W = 3,
   parameter int OUT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CODE_W-1:0] req_code,
   input  logic [CODE_W-1:0] req_count,
   input  logic [MODE_W-1:0] req_mode,
   output logic [OUT_W-1:0]  o,
   output logic              o_valid,
   output logic              o_last,
   output logic              err
);
   if (OUT_W < 2 || OUT_W > 2**CODE_W) begin : g_bad_out_w
      $error("lane_enable_sequencer: OUT_W must be in 2..2**CODE_W");
   end

   localparam logic [CODE_W-1:0] LAST_LANE = CODE_W'(OUT_W - 1);

   state_t            state;
   mode_t             mode;
   logic [CODE_W-1:0] cur, rem;
   logic [OUT_W-1:0]  dec;
   logic              accept, illegal;
   mode_t             req_mode_t;

   assign req_ready  = (state == IDLE);
   assign accept     = req_valid & req_ready & en;
   assign req_mode_t = mode_t'(req_mode);
   assign illegal    = (int'(req_code) >= OUT_W) || (req_mode_t == RSVD);

   onehot_dec_en #(.CODE_W(CODE_W), .OUT_W(OUT_W)) u_dec (
      .code (cur),
      .en   (mode != BCAST),
      .out  (dec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mode    <= SINGLE;
         cur     <= '0;
         rem     <= '0;
         o       <= '0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         err     <= 1'b0;
      end else begin
         // Outputs default to idle each cycle; only a live beat drives them.
         o       <= '0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     err <= 1'b1;
                  end else begin
                     cur   <= req_code;
                     rem   <= (req_mode_t == SWEEP) ? req_count : '0;
                     mode  <= req_mode_t;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (en) begin
                  o       <= (mode == BCAST) ? '1 : dec;
                  o_valid <= 1'b1;
                  o_last  <= (rem == '0);
                  if (rem == '0) begin
                     state <= IDLE;
                  end else begin
                     rem <= rem - 1'b1;
                     // Wrap at the real lane count, not at the code range.
                     cur <= (cur == LAST_LANE) ? '0 : cur + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lane_enable_sequencer.sv
// Directed bench: two instances (OUT_W=8 and OUT_W=6), table vectors plus stall/reset sequences.
module tb_lane_enable_sequencer;
   logic       clk = 1'b0;
   logic       rst, en, rv8, rv6;
   logic [2:0] req_code, req_count;
   logic [1:0] req_mode;
   logic       rdy8, rdy6, ov8, ov6, last8, last6, err8, err6;
   logic [7:0] o8;
   logic [5:0] o6;

   int total_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   lane_enable_sequencer #(.CODE_W(3), .OUT_W(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .req_valid(rv8), .req_ready(rdy8),
      .req_code(req_code), .req_count(req_count), .req_mode(req_mode),
      .o(o8), .o_valid(ov8), .o_last(last8), .err(err8)
   );

   lane_enable_sequencer #(.CODE_W(3), .OUT_W(6)) dut6 (
      .clk(clk), .rst(rst), .en(en), .req_valid(rv6), .req_ready(rdy6),
      .req_code(req_code), .req_count(req_count), .req_mode(req_mode),
      .o(o6), .o_valid(ov6), .o_last(last6), .err(err6)
   );

   typedef struct packed {
      logic        sel6;
      logic [1:0]  mode;
      logic [2:0]  code;
      logic [2:0]  count;
      logic        exp_err;
      logic [3:0]  nb;
      logic [79:0] beats;   // beat 0 in the top byte
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic sample(input logic sel6, output logic [7:0] so, output logic sov,
                         output logic slast, output logic serr, output logic srdy);
      so    = sel6 ? {2'b00, o6} : o8;
      sov   = sel6 ? ov6 : ov8;
      slast = sel6 ? last6 : last8;
      serr  = sel6 ? err6 : err8;
      srdy  = sel6 ? rdy6 : rdy8;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [7:0] so;
      logic sov, slast, serr, srdy;
      @(negedge clk);
      req_code = v.code; req_count = v.count; req_mode = v.mode; en = 1'b1;
      if (v.sel6) rv6 = 1'b1; else rv8 = 1'b1;
      @(negedge clk);
      rv6 = 1'b0; rv8 = 1'b0;
      sample(v.sel6, so, sov, slast, serr, srdy);
      chk($sformatf("v%0d_err", idx), serr, v.exp_err);
      chk($sformatf("v%0d_ov0", idx), sov, 1'b0);
      chk($sformatf("v%0d_rdy", idx), srdy, v.exp_err);
      for (int k = 0; k < int'(v.nb); k++) begin
         @(negedge clk);
         sample(v.sel6, so, sov, slast, serr, srdy);
         chk($sformatf("v%0d_o%0d", idx, k), so, v.beats[79-8*k -: 8]);
         chk($sformatf("v%0d_ov%0d", idx, k), sov, 1'b1);
         chk($sformatf("v%0d_last%0d", idx, k), slast, (k == int'(v.nb) - 1));
         if (k == int'(v.nb) - 1) chk($sformatf("v%0d_rdy_end", idx), srdy, 1'b1);
      end
      @(negedge clk);
      sample(v.sel6, so, sov, slast, serr, srdy);
      chk($sformatf("v%0d_after_ov", idx), sov, 1'b0);
      chk($sformatf("v%0d_after_err", idx), serr, 1'b0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 2'd1, 3'd6, 3'd3, 1'b0, 4'd4,  {8'h40, 8'h80, 8'h01, 8'h02, 48'h0}};
      vecs[1] = '{1'b1, 2'd0, 3'd6, 3'd0, 1'b1, 4'd0,  80'h0};
      vecs[2] = '{1'b1, 2'd1, 3'd4, 3'd2, 1'b0, 4'd3,  {8'h10, 8'h20, 8'h01, 56'h0}};
      vecs[3] = '{1'b0, 2'd2, 3'd0, 3'd5, 1'b0, 4'd1,  {8'hFF, 72'h0}};
      vecs[4] = '{1'b0, 2'd0, 3'd3, 3'd0, 1'b0, 4'd1,  {8'h08, 72'h0}};
      vecs[5] = '{1'b0, 2'd3, 3'd1, 3'd0, 1'b1, 4'd0,  80'h0};
      vecs[6] = '{1'b1, 2'd2, 3'd2, 3'd0, 1'b0, 4'd1,  {8'h3F, 72'h0}};
      vecs[7] = '{1'b0, 2'd1, 3'd7, 3'd7, 1'b0, 4'd8,
                  {8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 16'h0}};
      vecs[8] = '{1'b1, 2'd1, 3'd5, 3'd7, 1'b0, 4'd8,
                  {8'h20, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01, 16'h0}};

      rst = 1'b1; en = 1'b0; rv8 = 1'b0; rv6 = 1'b0;
      req_code = '0; req_count = '0; req_mode = '0;
      #2;
      chk("rst_o", o8, 8'h00);
      chk("rst_ov", ov8, 1'b0);
      chk("rst_err", err8, 1'b0);
      chk("rst_rdy", rdy8, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Stall: SWEEP 0 count 2, en low for two cycles after the first beat.
      @(negedge clk);
      req_code = 3'd0; req_count = 3'd2; req_mode = 2'd1; en = 1'b1; rv8 = 1'b1;
      @(negedge clk);
      rv8 = 1'b0;
      @(negedge clk);
      chk("stall_o0", o8, 8'h01); chk("stall_ov0", ov8, 1'b1);
      en = 1'b0;
      @(negedge clk);
      chk("stall_o1", o8, 8'h00); chk("stall_ov1", ov8, 1'b0);
      @(negedge clk);
      chk("stall_o2", o8, 8'h00); chk("stall_ov2", ov8, 1'b0);
      chk("stall_busy", rdy8, 1'b0);
      en = 1'b1;
      @(negedge clk);
      chk("stall_o3", o8, 8'h02); chk("stall_last3", last8, 1'b0);
      @(negedge clk);
      chk("stall_o4", o8, 8'h04); chk("stall_last4", last8, 1'b1);

      // Request with en low in IDLE must not be taken.
      @(negedge clk);
      en = 1'b0; req_code = 3'd1; req_mode = 2'd0; rv8 = 1'b1;
      @(negedge clk);
      chk("en0_rdy", rdy8, 1'b1);
      @(negedge clk);
      chk("en0_rdy2", rdy8, 1'b1);
      rv8 = 1'b0; en = 1'b1;
      @(negedge clk);
      chk("en0_ov", ov8, 1'b0);
      chk("en0_rdy3", rdy8, 1'b1);

      // Reset during the second beat of a four-beat sweep.
      @(negedge clk);
      req_code = 3'd0; req_count = 3'd3; req_mode = 2'd1; rv8 = 1'b1;
      @(negedge clk);
      rv8 = 1'b0;
      @(negedge clk);
      chk("rmid_o0", o8, 8'h01);
      @(negedge clk);
      chk("rmid_o1", o8, 8'h02);
      #2 rst = 1'b1;
      #1;
      chk("rmid_o", o8, 8'h00);
      chk("rmid_ov", ov8, 1'b0);
      chk("rmid_last", last8, 1'b0);
      chk("rmid_err", err8, 1'b0);
      chk("rmid_rdy", rdy8, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rpost_ov", ov8, 1'b0);
      chk("rpost_err", err8, 1'b0);
      run_vec(vecs[4], 99);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/lane_enable_sequencer.md
# lane_enable_sequencer

Parametrised, registered binary-to-one-hot enable generator for the vector datapath. It accepts a start code, a beat count and a mode over a valid/ready handshake, then emits one registered one-hot (or broadcast) enable word per cycle, walking consecutive lanes with wrap-around. A global stall input freezes the sweep and gates the output. It drives lane and register write-enables where a single combinational decode per instruction is insufficient.

## Interface
- CODE_W, 3, width of start code and beat count
- OUT_W, 8, number of enable lines; legal range 2..2**CODE_W (elaboration error otherwise)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enabler/stall; 0 holds state and forces o to 0
- req_valid  in  1  request present
- req_ready  out  1  block can accept; combinational, 1 only in IDLE
- req_code  in  CODE_W  first lane index
- req_count  in  CODE_W  beats minus one (0 means 1 beat)
- req_mode  in  2  SINGLE=0, SWEEP=1, BCAST=2, 3 reserved (treated as error)
- o  out  OUT_W  registered enable word
- o_valid  out  1  o carries a beat this cycle
- o_last  out  1  final beat of request, coincident with o_valid
- err  out  1  one-cycle pulse: rejected request

## Operation
- States: IDLE, RUN. Reset enters IDLE; all outputs 0, req_ready=1.
- Accept = req_valid & req_ready & en. With en=0 in IDLE, nothing is accepted.
- Rejection on accept if req_code >= OUT_W or req_mode==3: err=1 next cycle, stay IDLE, no beat.
- Legal accept: latch cur=req_code, rem=req_count (SINGLE and BCAST force rem=0), mode; go RUN.
- RUN, en=1: register one beat. SINGLE/SWEEP: o=onehot(cur). BCAST: o=all ones. o_valid=1; o_last=1 when rem==0.
- After a beat with rem!=0: rem-=1, cur=cur+1, wrapping from OUT_W-1 to 0 (not to 2**CODE_W-1).
- After a beat with rem==0: return to IDLE.
- RUN, en=0: cur, rem and state hold; next-cycle o=0, o_valid=0, o_last=0. Resumes the same lane when en returns.
- Count may exceed OUT_W-1: lanes repeat after wrap. Every beat is still emitted.
- Asynchronous rst mid-RUN: immediate IDLE, outputs 0; the request in flight is dropped silently (no err, no o_last).

## Timing
- Accept at edge t -> first beat visible after edge t+1; beat k after edge t+1+k plus stall cycles.
- Beats = req_count+1 for SWEEP, 1 for SINGLE/BCAST.
- req_ready falls the cycle after accept, rises the cycle after the o_last beat is registered; minimum one idle cycle between requests (back-to-back throughput = N beats per N+1 cycles).
- err registered: visible the cycle after the rejected accept; req_ready stays 1 throughout.
- o, o_valid, o_last are flops; no combinational path from req_* to outputs. req_ready depends on state only.

## Structure
- Package lane_seq_pkg: mode_t enum (SINGLE, SWEEP, BCAST, RSVD), state_t enum (IDLE, RUN), mode encoding width constant.
- Sub-module onehot_dec_en (parameters CODE_W, OUT_W): combinational code plus enable to one-hot, zero for codes >= OUT_W or enable low; reused by other decode sites.
- Top holds the FSM, cur/rem counters, wrap compare and output registers.

## Test plan
- Reset: assert rst mid-cycle -> o=0, o_valid=0, err=0, req_ready=1 immediately.
- SWEEP code=6, count=3, OUT_W=8 -> o = 0x40, 0x80, 0x01, 0x02 on four consecutive cycles, o_last on 0x02, req_ready back high the following cycle.
- OUT_W=6, code=6 -> err pulse, no beat; code=4 SWEEP count=2 -> 0x10, 0x20, 0x01 (wrap at 6).
- BCAST with count=5 -> single beat o=all ones with o_last; SINGLE code=3 -> one beat 0x08.
- Stall: SWEEP code=0 count=2, en low for 2 cycles after first beat -> 0x01, 0, 0, 0x02, 0x04; req_valid with en=0 in IDLE not accepted.
- rst asserted during beat 2 of a 4-beat SWEEP -> outputs 0 at once, no o_last, no err; next request accepted normally after release.
